// File: rtl/filt_pkg.sv
// Shared types and constants for the frame sequencer between the UART and the image filter.
package filt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_CHK    = 3'd2,
        ST_ACK    = 3'd3,
        ST_STREAM = 3'd4,
        ST_DRAIN  = 3'd5,
        ST_ERR    = 3'd6
    } seq_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h5A;
    localparam logic [7:0] ERR_BYTE  = 8'hEE;

    localparam int DIM_W = 10;
    localparam int CNT_W = 20;

    // A dimension is unusable when it is zero or larger than the limit.
    function automatic logic dim_bad(input logic [15:0] dim, input int max_dim);
        return (dim == 16'd0) || (dim > 16'(max_dim));
    endfunction

endpackage

// File: rtl/filt_frame_seq_hdr_parser.sv
// Collects the four header bytes into W and H and range-checks them
// during the single check cycle.
module hdr_parser
    import filt_pkg::*;
#(
    parameter int MAX_DIM = 640
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    input  logic             chk,
    output logic             done,
    output logic             ok,
    output logic             bad,
    output logic [DIM_W-1:0] w_lo,
    output logic [DIM_W-1:0] h_lo
);

    logic [1:0]  idx;
    logic [15:0] w;
    logic [15:0] h;
    logic        range_bad;

    // Byte index and big-endian W/H assembly; the index rewinds outside HDR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= 2'd0;
            w   <= 16'd0;
            h   <= 16'd0;
        end else if (!en) begin
            idx <= 2'd0;
        end else if (byte_valid) begin
            case (idx)
                2'd0:    w[15:8] <= byte_data;
                2'd1:    w[7:0]  <= byte_data;
                2'd2:    h[15:8] <= byte_data;
                2'd3:    h[7:0]  <= byte_data;
                default: w       <= w;
            endcase
            idx <= idx + 2'd1;
        end else begin
            idx <= idx;
        end
    end

    assign range_bad = dim_bad(w, MAX_DIM) || dim_bad(h, MAX_DIM);
    assign done      = en && byte_valid && (idx == 2'd3);
    assign ok        = chk && !range_bad;
    assign bad       = chk && range_bad;
    assign w_lo      = w[DIM_W-1:0];
    assign h_lo      = h[DIM_W-1:0];

endmodule

// File: rtl/filt_frame_seq.sv
// Frame sequencer: parses the host header, streams pixels into the filter and
// returns the filtered bytes over UART TX behind a reply byte.
module filt_frame_seq
    import filt_pkg::*;
#(
    parameter int         MAX_DIM     = 640,
    parameter int         TIMEOUT_CYC = 2_000_000,
    parameter logic [7:0] SYNC_BYTE   = filt_pkg::SYNC_BYTE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [7:0]       px_data,
    output logic             px_valid,
    input  logic             px_ready,
    input  logic [7:0]       fo_data,
    input  logic             fo_valid,
    output logic             fo_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    input  logic [3:0]       mode_sw,
    output logic [3:0]       cfg_mode,
    output logic [DIM_W-1:0] cfg_w,
    output logic [DIM_W-1:0] cfg_h,
    output logic             frame_start,
    output logic             busy,
    output logic             err_timeout,
    output logic             err_overrun,
    output logic             err_dim,
    output logic [15:0]      frame_cnt,
    output logic [2:0]       state_dbg
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    seq_state_t       state;
    seq_state_t       state_nx;
    logic [7:0]       hold;
    logic             hold_full;
    logic [CNT_W-1:0] total;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic [TW-1:0]    tmo_cnt;
    logic             hdr_done;
    logic             hdr_ok;
    logic             hdr_bad;
    logic [DIM_W-1:0] hdr_w;
    logic [DIM_W-1:0] hdr_h;
    logic             px_hs;
    logic             tx_hs;
    logic             out_open;
    logic             overrun;
    logic             timed;
    logic             tmo_hit;
    logic             frame_done;

    hdr_parser #(.MAX_DIM(MAX_DIM)) u_hdr (
        .clk        (clk),
        .rst        (rst),
        .en         (state == ST_HDR),
        .byte_valid (rx_valid),
        .byte_data  (rx_data),
        .chk        (state == ST_CHK),
        .done       (hdr_done),
        .ok         (hdr_ok),
        .bad        (hdr_bad),
        .w_lo       (hdr_w),
        .h_lo       (hdr_h)
    );

    // Output path stops once the frame's byte count has been returned.
    assign out_open = (out_cnt != total);

    // Per-state handshake outputs toward the filter and the UART.
    always_comb begin
        px_valid = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        fo_ready = 1'b0;
        case (state)
            ST_ACK: begin
                tx_valid = 1'b1;
                tx_data  = ACK_BYTE;
            end
            ST_STREAM: begin
                px_valid = hold_full;
                tx_valid = fo_valid && out_open;
                tx_data  = fo_data;
                fo_ready = tx_ready && out_open;
            end
            ST_DRAIN: begin
                tx_valid = fo_valid && out_open;
                tx_data  = fo_data;
                fo_ready = tx_ready && out_open;
            end
            ST_ERR: begin
                fo_ready = 1'b1;
                tx_valid = 1'b1;
                tx_data  = ERR_BYTE;
            end
            default: begin
                tx_data = 8'h00;
            end
        endcase
    end

    assign px_hs   = px_valid && px_ready;
    assign tx_hs   = tx_valid && tx_ready;
    assign overrun = (state == ST_STREAM) && rx_valid && hold_full && !px_hs;
    assign timed   = (state == ST_HDR) || (state == ST_ACK) ||
                     (state == ST_STREAM) || (state == ST_DRAIN);
    assign tmo_hit = timed && !(rx_valid || px_hs || tx_hs) &&
                     (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    // Next-state selection.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) state_nx = ST_HDR;
                else                                    state_nx = ST_IDLE;
            end
            ST_HDR: begin
                if (tmo_hit)       state_nx = ST_ERR;
                else if (hdr_done) state_nx = ST_CHK;
                else               state_nx = ST_HDR;
            end
            ST_CHK: begin
                if (hdr_bad) state_nx = ST_ERR;
                else         state_nx = ST_ACK;
            end
            ST_ACK: begin
                if (tmo_hit)    state_nx = ST_ERR;
                else if (tx_hs) state_nx = ST_STREAM;
                else            state_nx = ST_ACK;
            end
            ST_STREAM: begin
                if (overrun || tmo_hit) state_nx = ST_ERR;
                else if (in_cnt == total) state_nx = out_open ? ST_DRAIN : ST_IDLE;
                else                      state_nx = ST_STREAM;
            end
            ST_DRAIN: begin
                if (tmo_hit)       state_nx = ST_ERR;
                else if (!out_open) state_nx = ST_IDLE;
                else               state_nx = ST_DRAIN;
            end
            ST_ERR: begin
                if (tx_hs) state_nx = ST_IDLE;
                else       state_nx = ST_ERR;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign frame_done = ((state == ST_STREAM) || (state == ST_DRAIN)) && (state_nx == ST_IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // One-byte holding register between the UART and the filter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold      <= 8'h00;
            hold_full <= 1'b0;
        end else begin
            case (state)
                ST_ACK: begin
                    if (rx_valid) begin
                        hold      <= rx_data;
                        hold_full <= 1'b1;
                    end else begin
                        hold_full <= hold_full;
                    end
                end
                ST_STREAM: begin
                    if (rx_valid && (!hold_full || px_hs)) begin
                        hold      <= rx_data;
                        hold_full <= 1'b1;
                    end else if (px_hs) begin
                        hold_full <= 1'b0;
                    end else begin
                        hold_full <= hold_full;
                    end
                end
                default: hold_full <= 1'b0;
            endcase
        end
    end

    // Frame configuration and pixel counters, loaded during the check cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_mode    <= 4'd0;
            cfg_w       <= {DIM_W{1'b0}};
            cfg_h       <= {DIM_W{1'b0}};
            total       <= {CNT_W{1'b0}};
            in_cnt      <= {CNT_W{1'b0}};
            out_cnt     <= {CNT_W{1'b0}};
            frame_start <= 1'b0;
        end else begin
            frame_start <= hdr_ok;
            if (hdr_ok) begin
                cfg_mode <= mode_sw;
                cfg_w    <= hdr_w;
                cfg_h    <= hdr_h;
                total    <= CNT_W'(hdr_w) * CNT_W'(hdr_h);
            end else begin
                total <= total;
            end
            if (state == ST_CHK) begin
                in_cnt  <= {CNT_W{1'b0}};
                out_cnt <= {CNT_W{1'b0}};
            end else begin
                in_cnt  <= in_cnt + CNT_W'(px_hs);
                out_cnt <= out_cnt + CNT_W'(tx_hs && ((state == ST_STREAM) || (state == ST_DRAIN)));
            end
        end
    end

    // Inactivity counter; saturates so a stalled ERR reply cannot wrap it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                          tmo_cnt <= {TW{1'b0}};
        else if ((state == ST_IDLE) || rx_valid || px_hs || tx_hs) tmo_cnt <= {TW{1'b0}};
        else if (tmo_cnt != TW'(TIMEOUT_CYC))             tmo_cnt <= tmo_cnt + {{(TW-1){1'b0}}, 1'b1};
        else                                              tmo_cnt <= tmo_cnt;
    end

    // Sticky error flags and the completed-frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            err_dim     <= 1'b0;
            frame_cnt   <= 16'd0;
        end else begin
            err_timeout <= err_timeout || tmo_hit;
            err_overrun <= err_overrun || overrun;
            err_dim     <= err_dim || hdr_bad;
            frame_cnt   <= frame_cnt + {15'd0, frame_done};
        end
    end

    assign px_data   = hold;
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule

// File: doc/filt_frame_seq.md
Name: filt_frame_seq

Overview:
- Frame-level sequencer between the UART byte interfaces and the image-filter datapath.
- Parses a host frame header and checks the dimensions.
- Feeds pixel bytes into the filter with valid/ready, and returns the filter output over UART TX behind a reply byte.
- Counts frames, detects timeouts and overruns, and exports status for the LEDs and seven-segment display.

Parameters:
- MAX_DIM, 640, largest legal width or height in pixels.
- TIMEOUT_CYC, 2_000_000, idle cycles allowed inside a frame before abort.
- SYNC_BYTE, 8'hA5, header sync byte.

Ports:
- clk  in  1  design clock
- rst  in  1  asynchronous, active-high reset
- rx_data  in  8  received UART byte
- rx_valid  in  1  single-cycle strobe; no backpressure possible
- px_data  out  8  pixel to filter
- px_valid  out  1  pixel valid
- px_ready  in  1  filter accepts pixel
- fo_data  in  8  filtered pixel
- fo_valid  in  1  filtered pixel valid
- fo_ready  out  1  sequencer accepts filtered pixel
- tx_data  out  8  byte to UART TX
- tx_valid  out  1  TX request
- tx_ready  in  1  TX accepts byte
- mode_sw  in  4  filter select from switches
- cfg_mode  out  4  filter mode latched per frame
- cfg_w  out  10  frame width
- cfg_h  out  10  frame height
- frame_start  out  1  one-cycle pulse before the first pixel
- busy  out  1  high in every state except IDLE
- err_timeout  out  1  sticky flag, cleared by reset only
- err_overrun  out  1  sticky flag
- err_dim  out  1  sticky flag
- frame_cnt  out  16  completed frames, wraps at 16'hFFFF->0
- state_dbg  out  3  state encoding

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - All outputs 0, except cfg_mode=0, cfg_w=0, cfg_h=0.
  - State IDLE; counters 0; holding register empty.
  - Assertion mid-frame aborts immediately, with no reply byte.
- Host protocol: SYNC_BYTE, W_hi, W_lo, H_hi, H_lo, then W*H pixel bytes in raster order.
- Reply: 8'h5A, then W*H filtered bytes. Rejected or aborted frames get 8'hEE.
- States: IDLE=0, HDR=1, CHK=2, ACK=3, STREAM=4, DRAIN=5, ERR=6.
- IDLE:
  - rx_valid with rx_data==SYNC_BYTE -> HDR.
  - Any other byte is silently dropped.
- HDR:
  - Collects 4 bytes (idx 0..3) into 16-bit W and H.
  - After the 4th byte -> CHK.
- CHK (1 cycle):
  - If W==0, H==0, W>MAX_DIM or H>MAX_DIM: set err_dim -> ERR.
  - Otherwise: latch cfg_w, cfg_h (low 10 bits) and cfg_mode=mode_sw; total=W*H (20-bit, unsigned); pulse frame_start -> ACK.
- ACK:
  - tx_valid=1, tx_data=8'h5A until tx_ready -> STREAM.
  - fo_ready=0.
  - rx bytes arriving here are captured into the holding register.
- STREAM:
  - Input path: each rx_valid loads a 1-byte holding register. px_valid=hold_full, px_data=hold. A px handshake empties it.
  - Same-cycle rx_valid and px handshake: hold refills and stays full, no error.
  - rx_valid while hold_full with no handshake: set err_overrun -> ERR.
  - in_cnt increments per px handshake; in_cnt==total -> DRAIN.
  - Output path: tx_data=fo_data, tx_valid=fo_valid, fo_ready=tx_ready (combinational pass-through); out_cnt increments per tx handshake.
- DRAIN:
  - rx bytes are ignored; px_valid=0; output path as in STREAM.
  - out_cnt==total -> IDLE, frame_cnt+1.
  - If out_cnt reaches total while still in STREAM, the transition to IDLE happens when in_cnt also equals total.
- Timeout:
  - Counter clears on any rx_valid, px handshake or tx handshake, and in IDLE.
  - Reaching TIMEOUT_CYC in HDR, ACK, STREAM or DRAIN: set err_timeout -> ERR.
- ERR:
  - Drop the holding register; fo_ready=1 to flush the filter.
  - tx_valid=1, tx_data=8'hEE until tx_ready -> IDLE. frame_cnt is not incremented.
- Pixel count is fixed: the filter returns exactly W*H bytes. Extra fo_valid after out_cnt==total is not accepted (fo_ready=0 in IDLE).

Decomposition:
- Package filt_pkg holds:
  - state enum seq_state_t;
  - SYNC_BYTE, ACK_BYTE=8'h5A and ERR_BYTE=8'hEE;
  - the DIM_W=10 and CNT_W=20 width constants.
- One natural sub-module, hdr_parser: byte index, W/H assembly and the range check, with a done/bad pulse.

Test Plan:
- Send A5 00 03 00 02 plus 6 pixels, filter is a pass-through, tx_ready=1 -> TX stream 5A, then the 6 pixels; frame_start pulses once; frame_cnt=1; busy low after the last byte.
- Send 37 A5 00 00 00 04 -> the 37 is dropped; err_dim=1; TX 8'hEE; frame_cnt=0; state returns to IDLE.
- Send A5 02 81 00 01 (W=641) -> err_dim and EE reply; a following valid 2x2 frame completes normally.
- Hold px_ready=0 and send two pixel bytes back-to-back -> err_overrun=1 and EE reply; px_valid drops in ERR.
- Stop rx after 3 of 4 pixels with TIMEOUT_CYC=100 -> err_timeout exactly 100 cycles after the last rx_valid; EE reply.
- Assert rst mid-STREAM -> all outputs 0 on the next edge, no reply byte; a subsequent 1x1 frame returns 5A plus 1 byte.
